// File: rtl/car_motion_scheduler.sv
// Two-car motion update engine: per frame it turns, accelerates and moves both cars through one shared sin/cos LUT.
// Define CAR_COLLISION_EN to add the COLLIDE state; without it o_collision is tied low.
module car_motion_scheduler #(
    parameter int ANG_WIDTH    = 10,
    parameter int MAP_H_WIDTH  = 12,
    parameter int MAP_V_WIDTH  = 11,
    parameter int TRIG_WIDTH   = 8,
    parameter int ANG_STEP     = 5,
    parameter int SPEED_MAX    = 15,
    parameter int X_MIN        = -1000,
    parameter int X_MAX        = 1000,
    parameter int Y_MIN        = -500,
    parameter int Y_MAX        = 500,
    parameter int COLLIDE_DIST = 32
) (
    input  logic                          i_render_clk,
    input  logic                          i_rst,
    input  logic                          i_frame_tick,
    input  logic                          i_p1_left,
    input  logic                          i_p1_right,
    input  logic                          i_p1_accel,
    input  logic                          i_p2_left,
    input  logic                          i_p2_right,
    input  logic                          i_p2_accel,
    output logic                          o_trig_req,
    output logic signed [ANG_WIDTH-1:0]   o_trig_angle,
    input  logic                          i_trig_ack,
    input  logic signed [TRIG_WIDTH-1:0]  i_trig_cos,
    input  logic signed [TRIG_WIDTH-1:0]  i_trig_sin,
    output logic signed [ANG_WIDTH-1:0]   o_car1_angle,
    output logic signed [ANG_WIDTH-1:0]   o_car2_angle,
    output logic signed [MAP_H_WIDTH-1:0] o_car1_x,
    output logic signed [MAP_H_WIDTH-1:0] o_car2_x,
    output logic signed [MAP_V_WIDTH-1:0] o_car1_y,
    output logic signed [MAP_V_WIDTH-1:0] o_car2_y,
    output logic                          o_busy,
    output logic                          o_update_done,
    output logic                          o_overrun,
    output logic                          o_collision
);

    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam int FRAC  = TRIG_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        TRIG,
        MOVE,
        NEXT,
`ifdef CAR_COLLISION_EN
        COLLIDE,
`endif
        DONE
    } state_t;

    state_t                        state;
    logic                          parity;   // 0: car1 serviced first this frame
    logic                          cur;      // car being serviced (0 = car1)
    logic                          second;   // set once the first car of the frame is finished
    logic signed [ANG_WIDTH-1:0]   ang   [2];
    logic signed [MAP_H_WIDTH-1:0] pos_x [2];
    logic signed [MAP_V_WIDTH-1:0] pos_y [2];
    logic        [SPD_W-1:0]       spd   [2];
    logic signed [TRIG_WIDTH-1:0]  cos_q;
    logic signed [TRIG_WIDTH-1:0]  sin_q;

    logic                          sel_left, sel_right, sel_accel;
    logic signed [31:0]            turn_ang;
    logic        [SPD_W-1:0]       turn_spd;
    logic signed [31:0]            spd_s, step_x, step_y, move_x, move_y;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        sel_left  = cur ? i_p2_left  : i_p1_left;
        sel_right = cur ? i_p2_right : i_p1_right;
        sel_accel = cur ? i_p2_accel : i_p1_accel;

        turn_ang = 32'(ang[cur]);
        if (sel_left && !sel_right)
            turn_ang = turn_ang - ANG_STEP;
        else if (sel_right && !sel_left)
            turn_ang = turn_ang + ANG_STEP;
        if (turn_ang < 0)
            turn_ang = turn_ang + 360;
        else if (turn_ang >= 360)
            turn_ang = turn_ang - 360;

        turn_spd = spd[cur];
        if (sel_accel) begin
            if (spd[cur] < SPD_W'(SPEED_MAX))
                turn_spd = spd[cur] + SPD_W'(1);
        end else if (spd[cur] != '0) begin
            turn_spd = spd[cur] - SPD_W'(1);
        end

        // Full-precision product, then floor shift back out of the Q1.FRAC trig scale.
        spd_s  = $signed(32'(spd[cur]));
        step_x = (spd_s * 32'(cos_q)) >>> FRAC;
        step_y = (spd_s * 32'(sin_q)) >>> FRAC;
        move_x = 32'(pos_x[cur]) + step_x;
        move_y = 32'(pos_y[cur]) + step_y;
        if (move_x < X_MIN) move_x = X_MIN;
        if (move_x > X_MAX) move_x = X_MAX;
        if (move_y < Y_MIN) move_y = Y_MIN;
        if (move_y > Y_MAX) move_y = Y_MAX;
    end

`ifdef CAR_COLLISION_EN
    logic signed [31:0] sep_x, sep_y;
    logic               hit;

    always_comb begin
        sep_x = 32'(pos_x[0]) - 32'(pos_x[1]);
        sep_y = 32'(pos_y[0]) - 32'(pos_y[1]);
        if (sep_x < 0) sep_x = -sep_x;
        if (sep_y < 0) sep_y = -sep_y;
        hit = (sep_x < COLLIDE_DIST) && (sep_y < COLLIDE_DIST);
    end
`else
    assign o_collision = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge i_render_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            parity        <= 1'b0;
            cur           <= 1'b0;
            second        <= 1'b0;
            // NOTE: the two-entry car arrays are reset because their values are architectural outputs.
            ang[0]        <= ANG_WIDTH'(60);
            ang[1]        <= ANG_WIDTH'(120);
            pos_x[0]      <= MAP_H_WIDTH'(0);
            pos_x[1]      <= MAP_H_WIDTH'(650);
            pos_y[0]      <= MAP_V_WIDTH'(250);
            pos_y[1]      <= MAP_V_WIDTH'(-250);
            spd[0]        <= '0;
            spd[1]        <= '0;
            cos_q         <= '0;
            sin_q         <= '0;
            o_trig_req    <= 1'b0;
            o_trig_angle  <= '0;
            o_busy        <= 1'b0;
            o_update_done <= 1'b0;
            o_overrun     <= 1'b0;
`ifdef CAR_COLLISION_EN
            o_collision   <= 1'b0;
`endif
        end else begin
            o_update_done <= 1'b0;
`ifdef CAR_COLLISION_EN
            o_collision   <= 1'b0;
`endif
            if (i_frame_tick && state != IDLE)
                o_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (i_frame_tick) begin
                        state  <= TURN;
                        cur    <= parity;
                        second <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end
                TURN: begin
                    ang[cur]     <= ANG_WIDTH'(turn_ang);
                    spd[cur]     <= turn_spd;
                    o_trig_req   <= 1'b1;
                    o_trig_angle <= ANG_WIDTH'(turn_ang);
                    state        <= TRIG;
                end
                TRIG: begin
                    if (i_trig_ack && o_trig_req) begin
                        cos_q      <= i_trig_cos;
                        sin_q      <= i_trig_sin;
                        o_trig_req <= 1'b0;
                        state      <= MOVE;
                    end
                end
                MOVE: begin
                    pos_x[cur] <= MAP_H_WIDTH'(move_x);
                    pos_y[cur] <= MAP_V_WIDTH'(move_y);
                    state      <= NEXT;
                end
                NEXT: begin
                    if (!second) begin
                        second <= 1'b1;
                        cur    <= ~cur;
                        state  <= TURN;
                    end else begin
`ifdef CAR_COLLISION_EN
                        state         <= COLLIDE;
`else
                        state         <= DONE;
                        o_update_done <= 1'b1;
`endif
                    end
                end
`ifdef CAR_COLLISION_EN
                COLLIDE: begin
                    if (hit) begin
                        spd[0]      <= '0;
                        spd[1]      <= '0;
                        o_collision <= 1'b1;
                    end
                    state         <= DONE;
                    o_update_done <= 1'b1;
                end
`endif
                DONE: begin
                    parity <= ~parity;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_car1_angle = ang[0];
    assign o_car2_angle = ang[1];
    assign o_car1_x     = pos_x[0];
    assign o_car2_x     = pos_x[1];
    assign o_car1_y     = pos_y[0];
    assign o_car2_y     = pos_y[1];

endmodule
